// File: rtl/tv80_bus_ctrl.sv
// Z80 bus-cycle strobe generator with programmable automatic wait states per cycle class.
// Optional build macro TV80_REFRESH_EN: drive mreq_n low during M1 T4 (refresh cycle).
module tv80_bus_ctrl #(
  parameter int DW       = 8,
  parameter int T2_WRITE = 1,
  parameter int M1_WAIT  = 0,
  parameter int MEM_WAIT = 0,
  parameter int IO_WAIT  = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clken,
  input  logic [6:0]    mcycle,
  input  logic [6:0]    tstate,
  input  logic          intcycle_n,
  input  logic          no_read,
  input  logic          write,
  input  logic          iorq,
  input  logic          ext_wait_n,
  input  logic [DW-1:0] di_bus,
  output logic          core_wait_n,
  output logic          rd_n,
  output logic          wr_n,
  output logic          mreq_n,
  output logic          iorq_n,
  output logic [DW-1:0] di_reg,
  output logic          wait_busy
);

  localparam logic [3:0] M1_WCNT  = 4'(M1_WAIT);
  localparam logic [3:0] MEM_WCNT = 4'(MEM_WAIT);
  localparam logic [3:0] IO_WCNT  = 4'(IO_WAIT);
  localparam bit         WR_EARLY = (T2_WRITE != 0);

  logic          rd_n_q, rd_n_d;
  logic          wr_n_q, wr_n_d;
  logic          mreq_n_q, mreq_n_d;
  logic          iorq_n_q, iorq_n_d;
  logic [3:0]    wcnt_q, wcnt_d;
  logic [DW-1:0] di_reg_q;

  logic          access;
  logic          wr_strobe;
  logic          bus_pending;
  logic [3:0]    wcnt_load_val;
  logic          unused_inputs;

  // Only M1 is decoded from mcycle and only T1..T3 from tstate.
  assign unused_inputs = ^{mcycle[6:1], tstate[6:3], tstate[0]};

  assign core_wait_n = ext_wait_n & (wcnt_q == 4'd0);
  assign wait_busy   = (wcnt_q != 4'd0);

  // Strobes are launched in T1 and held through every stalled T2.
  assign access    = tstate[1] | (tstate[2] & ~core_wait_n);
  assign wr_strobe = WR_EARLY ? (access & write) : (tstate[2] & write);

  always_comb begin
    rd_n_d   = 1'b1;
    wr_n_d   = 1'b1;
    mreq_n_d = 1'b1;
    iorq_n_d = 1'b1;
    if (mcycle[0]) begin
      if (access) begin
        rd_n_d   = ~intcycle_n;
        mreq_n_d = ~intcycle_n;
        iorq_n_d = intcycle_n;
      end
`ifdef TV80_REFRESH_EN
      if (tstate[3]) begin
        mreq_n_d = 1'b0;
      end
`endif
    end else begin
      if (access && !no_read && !write) begin
        rd_n_d   = 1'b0;
        iorq_n_d = ~iorq;
        mreq_n_d = iorq;
      end
      if (wr_strobe) begin
        wr_n_d   = 1'b0;
        iorq_n_d = ~iorq;
        mreq_n_d = iorq;
      end
    end
  end

  assign bus_pending = mcycle[0] | ~no_read | write;

  always_comb begin
    if (mcycle[0] && intcycle_n) begin
      wcnt_load_val = M1_WCNT;
    end else if (mcycle[0] || iorq) begin
      wcnt_load_val = IO_WCNT;
    end else begin
      wcnt_load_val = MEM_WCNT;
    end
  end

  // Counter keeps running while ext_wait_n is low, so stalls overlap rather than add.
  always_comb begin
    wcnt_d = wcnt_q;
    if (tstate[1] && bus_pending) begin
      wcnt_d = wcnt_load_val;
    end else if (wcnt_q != 4'd0) begin
      wcnt_d = wcnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_n_q   <= 1'b1;
      wr_n_q   <= 1'b1;
      mreq_n_q <= 1'b1;
      iorq_n_q <= 1'b1;
      wcnt_q   <= 4'd0;
      di_reg_q <= '0;
    end else if (clken) begin
      rd_n_q   <= rd_n_d;
      wr_n_q   <= wr_n_d;
      mreq_n_q <= mreq_n_d;
      iorq_n_q <= iorq_n_d;
      wcnt_q   <= wcnt_d;
      if (tstate[2] && core_wait_n) begin
        di_reg_q <= di_bus;
      end
    end
  end

  assign rd_n   = rd_n_q;
  assign wr_n   = wr_n_q;
  assign mreq_n = mreq_n_q;
  assign iorq_n = iorq_n_q;
  assign di_reg = di_reg_q;

endmodule

// File: tb/tb_tv80_bus_ctrl.sv
// Bench for tv80_bus_ctrl: a zero-wait instance and a waited instance driven by a simple core model.
module tb_tv80_bus_ctrl;

  localparam logic [6:0] T1 = 7'b0000010;
  localparam logic [6:0] T2 = 7'b0000100;
  localparam logic [6:0] T3 = 7'b0001000;
  localparam logic [6:0] T4 = 7'b0010000;
`ifdef TV80_REFRESH_EN
  localparam bit REFRESH = 1'b1;
`else
  localparam bit REFRESH = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n, clken;
  logic [6:0] mcycle, tstate;
  logic       intcycle_n, no_read, write, iorq, ext_wait_n;
  logic [7:0] di_bus;
  logic       sel;

  logic       cw0, rd0, wr0, mq0, io0, bz0;
  logic [7:0] dr0;
  logic       cw1, rd1, wr1, mq1, io1, bz1;
  logic [7:0] dr1;

  always #5 clk = ~clk;

  tv80_bus_ctrl #(.DW(8), .T2_WRITE(1), .M1_WAIT(0), .MEM_WAIT(0), .IO_WAIT(0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .clken(clken), .mcycle(mcycle), .tstate(tstate),
    .intcycle_n(intcycle_n), .no_read(no_read), .write(write), .iorq(iorq),
    .ext_wait_n(ext_wait_n), .di_bus(di_bus), .core_wait_n(cw0), .rd_n(rd0), .wr_n(wr0),
    .mreq_n(mq0), .iorq_n(io0), .di_reg(dr0), .wait_busy(bz0)
  );

  tv80_bus_ctrl #(.DW(8), .T2_WRITE(0), .M1_WAIT(3), .MEM_WAIT(2), .IO_WAIT(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .clken(clken), .mcycle(mcycle), .tstate(tstate),
    .intcycle_n(intcycle_n), .no_read(no_read), .write(write), .iorq(iorq),
    .ext_wait_n(ext_wait_n), .di_bus(di_bus), .core_wait_n(cw1), .rd_n(rd1), .wr_n(wr1),
    .mreq_n(mq1), .iorq_n(io1), .di_reg(dr1), .wait_busy(bz1)
  );

  typedef struct {
    string      tag;
    logic [5:0] vec;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // {rd_n, wr_n, mreq_n, iorq_n, core_wait_n, wait_busy} of the selected instance
  function automatic logic [5:0] obs_vec();
    return sel ? {rd1, wr1, mq1, io1, cw1, bz1} : {rd0, wr0, mq0, io0, cw0, bz0};
  endfunction

  function automatic logic [7:0] obs_di();
    return sel ? dr1 : dr0;
  endfunction

  function automatic logic obs_cw();
    return sel ? cw1 : cw0;
  endfunction

  function automatic int auto_waits(input bit s, input bit m1, input bit int_n,
                                    input bit io, input bit nrd, input bit wr);
    if (!s) return 0;
    if (!m1 && nrd && !wr) return 0;
    if (m1 && int_n) return 3;
    if (m1 || io) return 1;
    return 2;
  endfunction

  task automatic sb_push(input string tag, input logic [3:0] st, input bit cw, input bit bz);
    exp_t e;
    e.tag = tag;
    e.vec = {st, cw, bz};
    exp_q.push_back(e);
  endtask

  task automatic sb_pop(input string name);
    exp_t e;
    if (exp_q.size() == 0) begin
      check_eq({name, "_sb_empty"}, exp_q.size(), 1);
      return;
    end
    e = exp_q.pop_front();
    check_eq({name, "_", e.tag}, obs_vec(), e.vec);
  endtask

  task automatic run_cycle(input bit s, input string name, input bit m1, input bit int_n,
                           input bit nrd, input bit wr, input bit io, input int ext_low,
                           input logic [7:0] data, input bit freeze);
    int         nauto, n_t2, k;
    logic [3:0] act, st;
    bit         late_wr, done;
    exp_t       e_frz;
    sel   = s;
    nauto = auto_waits(s, m1, int_n, io, nrd, wr);
    n_t2  = ((nauto > ext_low) ? nauto : ext_low) + 1;
    if (m1)        act = int_n ? 4'b0101 : 4'b1110;
    else if (wr)   act = io ? 4'b1010 : 4'b1001;
    else if (!nrd) act = io ? 4'b0110 : 4'b0101;
    else           act = 4'b1111;
    late_wr = s && !m1 && wr;
    for (int i = 1; i <= n_t2; i++) begin
      st = (late_wr && i == 1) ? 4'b1111 : act;
      sb_push($sformatf("t2_%0d", i), st, (i > ext_low) && (i > nauto), i <= nauto);
    end
    sb_push("t3", late_wr ? act : 4'b1111, 1'b1, 1'b0);
    sb_push("t4", (m1 && REFRESH) ? 4'b1101 : 4'b1111, 1'b1, 1'b0);
    sb_push("idle", 4'b1111, 1'b1, 1'b0);

    @(negedge clk);
    mcycle     = m1 ? 7'b0000001 : 7'b0000010;
    intcycle_n = int_n;
    no_read    = nrd;
    write      = wr;
    iorq       = io;
    tstate     = T1;
    ext_wait_n = 1'b1;
    di_bus     = ~data;
    k    = 0;
    done = 1'b0;
    while (!done && k < 40) begin
      @(negedge clk);
      k++;
      tstate     = T2;
      ext_wait_n = (k > ext_low);
      #1;
      if (exp_q.size() > 0) e_frz = exp_q[0];
      sb_pop(name);
      if (freeze && k == 2) begin
        clken = 1'b0;
        for (int f = 0; f < 4; f++) begin
          @(posedge clk);
          @(negedge clk);
          #1;
          check_eq($sformatf("%s_frz%0d", name, f), obs_vec(), e_frz.vec);
        end
        clken = 1'b1;
      end
      if (obs_cw()) begin
        di_bus = data;
        done   = 1'b1;
      end else begin
        di_bus = ~data;
      end
    end
    if (!done) check_eq({name, "_t2_timeout"}, k, n_t2);

    @(negedge clk);
    tstate     = T3;
    di_bus     = ~data;
    ext_wait_n = 1'b1;
    #1;
    sb_pop(name);
    check_eq({name, "_di_t3"}, obs_di(), data);
    @(negedge clk);
    tstate = T4;
    #1;
    sb_pop(name);
    @(negedge clk);
    tstate = 7'd0;
    mcycle = 7'd0;
    #1;
    sb_pop(name);
    check_eq({name, "_di_idle"}, obs_di(), data);
    check_eq({name, "_sb_left"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n    = 1'b0;
    clken      = 1'b1;
    mcycle     = 7'd0;
    tstate     = 7'd0;
    intcycle_n = 1'b1;
    no_read    = 1'b1;
    write      = 1'b0;
    iorq       = 1'b0;
    ext_wait_n = 1'b1;
    di_bus     = 8'h00;
    sel        = 1'b0;

    #12;
    check_eq("rst0_strobes", obs_vec(), 6'b111110);
    check_eq("rst0_di", obs_di(), 8'h00);
    sel = 1'b1;
    check_eq("rst1_strobes", obs_vec(), 6'b111110);
    ext_wait_n = 1'b0;
    #1;
    check_eq("rst1_cw_follows_ext", obs_cw(), 1'b0);
    ext_wait_n = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;

    // zero-wait instance, T2_WRITE=1
    run_cycle(1'b0, "z_m1",    1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 8'hA5, 1'b0);
    run_cycle(1'b0, "z_memrd", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 8'h3C, 1'b0);
    run_cycle(1'b0, "z_iord",  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 8'h5A, 1'b0);
    run_cycle(1'b0, "z_memwr", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 8'h81, 1'b0);
    run_cycle(1'b0, "z_iowr",  1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 0, 8'h42, 1'b0);
    run_cycle(1'b0, "z_inta",  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 8'hFF, 1'b0);
    run_cycle(1'b0, "z_extw",  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3, 8'h19, 1'b0);

    // waited instance: M1=3, MEM=2, IO=1, T2_WRITE=0
    run_cycle(1'b1, "w_m1",    1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 8'hC3, 1'b1);
    run_cycle(1'b1, "w_iowr",  1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 0, 8'h6E, 1'b0);
    run_cycle(1'b1, "w_memrd_ext5", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5, 8'h27, 1'b0);
    run_cycle(1'b1, "w_memwr", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 8'h90, 1'b0);
    run_cycle(1'b1, "w_inta",  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 8'hE7, 1'b0);
    run_cycle(1'b1, "w_iord",  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 8'h0F, 1'b0);
    run_cycle(1'b1, "w_noread", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 8'hB4, 1'b0);
    for (int i = 0; i < 4; i++) begin
      int         ext;
      logic [7:0] d;
      ext = int'($urandom_range(0, 4));
      d   = 8'($urandom);
      run_cycle(1'b1, $sformatf("rnd%0d", i), 1'b0, 1'b1, 1'b0, 1'b0, i[0], ext, d, 1'b0);
    end

    // reset asserted in the middle of an INTA wait state
    sel = 1'b1;
    @(negedge clk);
    mcycle     = 7'b0000001;
    intcycle_n = 1'b0;
    no_read    = 1'b0;
    write      = 1'b0;
    iorq       = 1'b0;
    tstate     = T1;
    ext_wait_n = 1'b1;
    di_bus     = 8'h77;
    @(negedge clk);
    tstate = T2;
    #1;
    check_eq("inta_pre_rst", obs_vec(), {4'b1110, 1'b0, 1'b1});
    #1;
    reset_n = 1'b0;
    #1;
    check_eq("rst_mid_strobes", obs_vec(), 6'b111110);
    check_eq("rst_mid_di", obs_di(), 8'h00);
    @(negedge clk);
    reset_n    = 1'b1;
    mcycle     = 7'd0;
    tstate     = 7'd0;
    intcycle_n = 1'b1;
    run_cycle(1'b1, "post_rst_m1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1, 8'h5E, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
